// File: rtl/bus_arbiter.sv
// Two-master (data, instruction fetch) arbiter onto a single Wishbone-style bus.
// Data has fixed priority; each transaction is bounded by a TIMEOUT-cycle watchdog.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,

  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,

  input  logic        flush_i,

  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  // Counter only ever holds 0..TIMEOUT-1; the last value triggers the abort.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyMem, StBusyIf, StDone} state_e;
  typedef enum logic {OwnerMem, OwnerIf} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rbuf_q, rbuf_d;
  logic            discard_q, discard_d;
  logic            err_q, err_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic start_mem, start_if, timeout, done_mem, done_if;

  assign timeout  = (cnt_q == CntLast) && !bus_ack_i;
  assign done_mem = (state_q == StDone) && (owner_q == OwnerMem);
  assign done_if  = (state_q == StDone) && (owner_q == OwnerIf);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rbuf_d    = rbuf_q;
    discard_d = discard_q;
    err_d     = 1'b0;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    start_mem = 1'b0;
    start_if  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_ce_i) begin
          start_mem = 1'b1;
        end else if (if_ce_i) begin
          start_if = 1'b1;
        end
      end
      StBusyMem, StBusyIf: begin
        if ((state_q == StBusyIf) && flush_i) begin
          discard_d = 1'b1;
        end
        if (bus_ack_i || timeout) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          err_d   = !bus_ack_i;
          rbuf_d  = (bus_ack_i && !we_q) ? bus_data_i : '0;
          // A flushed fetch still finishes on the bus but never reaches the fetch port.
          if ((state_q == StBusyIf) && (discard_q || flush_i)) begin
            state_d   = StIdle;
            discard_d = 1'b0;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!mem_ce_i && if_ce_i) begin
          start_if = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_mem) begin
      state_d = StBusyMem;
      owner_d = OwnerMem;
      cnt_d   = '0;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = mem_we_i;
      sel_d   = mem_sel_i;
      addr_d  = mem_addr_i;
      wdata_d = mem_data_i;
    end else if (start_if) begin
      state_d = StBusyIf;
      owner_d = OwnerIf;
      cnt_d   = '0;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = 1'b0;
      sel_d   = 4'b1111;
      addr_d  = if_addr_i;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnerMem;
      cnt_q     <= '0;
      rbuf_q    <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rbuf_q    <= rbuf_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus_cyc_o      = cyc_q;
  assign bus_stb_o      = stb_q;
  assign bus_we_o       = we_q;
  assign bus_sel_o      = sel_q;
  assign bus_addr_o     = addr_q;
  assign bus_data_o     = wdata_q;
  assign bus_err_o      = err_q;

  assign mem_data_o     = done_mem ? rbuf_q : '0;
  assign if_data_o      = done_if ? rbuf_q : '0;
  assign mem_stallreq_o = mem_ce_i && !done_mem;
  assign if_stallreq_o  = if_ce_i && !done_if;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for bus_ack_i before the block aborts the transaction.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have these instruction-fetch ports: if_ce_i in 1 (fetch request); if_addr_i in 32; if_data_o out 32 (fetched word); if_stallreq_o out 1.
REQ-005 The block SHALL have these data ports: mem_ce_i in 1; mem_we_i in 1; mem_sel_i in 4; mem_addr_i in 32; mem_data_i in 32 (write data); mem_data_o out 32 (read data); mem_stallreq_o out 1.
REQ-006 The block SHALL have flush_i, input, 1 bit: discards any in-flight fetch result.
REQ-007 The block SHALL have these shared-bus ports: bus_cyc_o out 1; bus_stb_o out 1; bus_we_o out 1; bus_sel_o out 4; bus_addr_o out 32; bus_data_o out 32; bus_data_i in 32; bus_ack_i in 1.
REQ-008 The block SHALL have bus_err_o, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-009 The block SHALL implement states IDLE, BUSY_MEM, BUSY_IF and DONE, plus a registered owner flag (MEM/IF).
REQ-010 In IDLE, data has fixed priority: if mem_ce_i=1, the block SHALL go to BUSY_MEM; otherwise, if if_ce_i=1, it SHALL go to BUSY_IF; otherwise it SHALL stay in IDLE.
REQ-011 On entry to a BUSY state, the block SHALL register the requester's address, sel and write data onto the bus. Fetch SHALL use sel=4'b1111 and we=0.
REQ-012 In the same edge that enters a BUSY state, the block SHALL assert bus_cyc_o and bus_stb_o, and SHALL hold all bus outputs stable until the transaction terminates.
REQ-013 In BUSY, on a cycle with bus_ack_i=1, the block SHALL capture bus_data_i into the read buffer. At the next edge it SHALL deassert cyc/stb and go to DONE.
REQ-014 Bus acks are ignored in IDLE and DONE.
REQ-015 In DONE, the block SHALL drive the buffer onto the owner's data output (mem_data_o or if_data_o) for exactly one cycle, then go to IDLE.
REQ-016 For a completed write, the owner's data output SHALL be 0x00000000.
REQ-017 The non-owner data output SHALL be 0x00000000 at all times.
REQ-018 The stall outputs SHALL be combinational:
- mem_stallreq_o = mem_ce_i AND NOT(state=DONE AND owner=MEM).
- if_stallreq_o = if_ce_i AND NOT(state=DONE AND owner=IF).
REQ-019 A requester holds its request signals stable while its stall is high; the block SHALL NOT re-sample them during BUSY.
REQ-020 A cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-021 When the counter reaches TIMEOUT with no ack, the block SHALL:
- deassert cyc/stb at the next edge;
- load the buffer with 0x00000000;
- pulse bus_err_o for one cycle;
- proceed to DONE.
REQ-022 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no bus_err_o.
REQ-023 If flush_i=1 in any cycle while owner=IF and state is BUSY_IF, the block SHALL set a discard flag; the bus cycle SHALL still complete normally.
REQ-024 When the discard flag is set, the block SHALL go from BUSY_IF directly to IDLE, skipping DONE (no if_data_o pulse), and clear the flag.
REQ-025 flush_i SHALL have no effect on data transactions.
REQ-026 If mem_ce_i and if_ce_i rise in the same IDLE cycle, the block SHALL service data first and the fetch next. A fetch issued back-to-back after DONE SHALL enter BUSY_IF on the edge leaving DONE only if mem_ce_i=0 in that cycle.

Reset
REQ-027 While rst=0, the block SHALL be in IDLE with owner=MEM, counter=0, buffer=0 and discard flag=0.
REQ-028 While rst=0, all bus_* outputs, if_data_o, mem_data_o and bus_err_o SHALL be 0. Stall outputs SHALL follow REQ-018 with state=IDLE.
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately: cyc/stb drop asynchronously, and there is no DONE pulse.

Verification
REQ-030 Fetch: if_ce_i=1, addr=0x100, ack two cycles after stb -> if_stallreq_o high until the DONE cycle, if_data_o=bus word for exactly one cycle, then IDLE.
REQ-031 Contention: mem_ce_i=1 read 0x2000 and if_ce_i=1 together -> bus_addr_o=0x2000 first, then 0x100. if_stallreq_o stays high throughout the data transaction.
REQ-032 Write: mem_we_i=1, sel=4'b0011, data=0xDEADBEEF -> bus_we_o=1, bus_sel_o=0011, bus_data_o=0xDEADBEEF, mem_data_o=0 in DONE.
REQ-033 Timeout: TIMEOUT=4, never ack -> cyc drops after 4 BUSY cycles, bus_err_o one-cycle pulse, returned data 0. Repeat with ack on cycle 4 -> no error.
REQ-034 Flush: flush_i pulsed during BUSY_IF -> bus cycle completes, no if_data_o pulse, and a pending mem_ce_i is granted on the next IDLE.
REQ-035 Reset: rst=0 during BUSY_MEM -> bus_cyc_o=0 with no clock edge. After release -> IDLE, all outputs 0.
